// File: rtl/boreal_cmd_sequencer.sv
// boreal_cmd_sequencer
// Round-robin arbiter that funnels N_REQ firmware command sources onto the
// single fw_act/fw_val channel, each grant held for HOLD_CYCLES cycles. The
// same block also acts as the AXI4-Lite write master that kicks the watchdog,
// but only when at least one command was accepted during the kick period.
// A stalled control loop therefore stops the kicks and lets the watchdog
// force BRAKE.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   enable             1 = watchdog kicks allowed (arbitration always runs)
//   err_clr            pulse, clears kick_err and starved
//   req_valid/ready    per-requester handshake; ready is one-hot or zero
//   req_act/req_val    packed per-requester action IDs (8b) and values (16b)
//   fw_act/fw_val      registered command to the watchdog/safety mux
//   cmd_strobe         one-cycle pulse when fw_act/fw_val update
//   grant_id           index of the last granted requester
//   m_axi_*            AXI4-Lite write channels (AW, W, B)
//   kick_err           sticky: bad write response or kick overlap
//   starved            sticky: kick skipped because no command was accepted
module boreal_cmd_sequencer #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned KICK_PERIOD = 6,
   parameter logic [31:0] WDT_BASE    = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  err_clr,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [8*N_REQ-1:0]    req_act,
   input  logic [16*N_REQ-1:0]   req_val,
   output logic [7:0]            fw_act,
   output logic [15:0]           fw_val,
   output logic                  cmd_strobe,
   output logic [2:0]            grant_id,
   output logic [31:0]           m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic                  kick_err,
   output logic                  starved
);

   localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned PER_W     = $clog2(KICK_PERIOD + 1);
   localparam logic [31:0] KICK_ADDR = WDT_BASE + 32'h0000_0004;
   localparam logic [31:0] KICK_DATA = 32'h1CEB_00DA;

   typedef enum logic {
      A_IDLE,
      A_HOLD
   } arb_state_t;

   typedef enum logic [1:0] {
      K_IDLE,
      K_REQ,
      K_RESP
   } kick_state_t;

   arb_state_t          arb_state;
   arb_state_t          arb_next;
   kick_state_t         kick_state;
   kick_state_t         kick_next;

   logic [2:0]          ptr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [PER_W-1:0]    per_cnt;
   logic                activity;

   logic                win_found;
   logic [2:0]          win_idx;
   logic [7:0]          win_act;
   logic [15:0]         win_val;
   logic                accept;
   logic                hold_done;
   logic                tc;

   logic                kick_issue;
   logic                starve_set;
   logic                kick_err_set;
   logic                aw_pending;
   logic                w_pending;

   // ------------------------------------------------------------------
   // Round-robin winner search: the lowest valid index at or above ptr
   // wins; if none, the lowest valid index overall (wrap-around).
   // ------------------------------------------------------------------
   always_comb begin
      logic       hi_found;
      logic [2:0] hi_idx;
      logic       lo_found;
      logic [2:0] lo_idx;
      hi_found = 1'b0;
      hi_idx   = 3'd0;
      lo_found = 1'b0;
      lo_idx   = 3'd0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(i);
            if (3'(i) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end
         end
      end
      win_found = lo_found;
      win_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Payload mux for the winning requester
   always_comb begin
      win_act = 8'h00;
      win_val = 16'h0000;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (win_idx == 3'(i)) begin
            win_act = req_act[8*i +: 8];
            win_val = req_val[16*i +: 16];
         end
      end
   end

   // ------------------------------------------------------------------
   // Arbiter FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         arb_state <= A_IDLE;
      end else begin
         arb_state <= arb_next;
      end
   end

   assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

   always_comb begin
      arb_next = arb_state;
      case (arb_state)
         A_IDLE: if (win_found) arb_next = A_HOLD;
         A_HOLD: if (hold_done) arb_next = A_IDLE;
         default: arb_next = A_IDLE;
      endcase
   end

   // req_ready is intentionally combinational so a request is accepted in
   // the same cycle it is granted.
   always_comb begin
      accept    = (arb_state == A_IDLE) && win_found;
      req_ready = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         req_ready[i] = accept && (win_idx == 3'(i));
      end
   end

   // Arbiter datapath: hold counter, captured command, pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         ptr        <= 3'd0;
         fw_act     <= 8'h00;
         fw_val     <= 16'h0000;
         cmd_strobe <= 1'b0;
         grant_id   <= 3'd0;
      end else begin
         cmd_strobe <= accept;
         if (arb_state == A_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end else begin
            hold_cnt <= '0;
         end
         if (accept) begin
            fw_act   <= win_act;
            fw_val   <= win_val;
            grant_id <= win_idx;
            ptr      <= (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Kick period counter, free running 0..KICK_PERIOD-1
   // ------------------------------------------------------------------
   assign tc = (per_cnt == PER_W'(KICK_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt <= '0;
      end else if (tc) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + PER_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Kick FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         kick_state <= K_IDLE;
      end else begin
         kick_state <= kick_next;
      end
   end

   // A channel is still pending if its valid is up and ready is not seen
   assign aw_pending = m_axi_awvalid && !m_axi_awready;
   assign w_pending  = m_axi_wvalid && !m_axi_wready;

   always_comb begin
      kick_next = kick_state;
      case (kick_state)
         K_IDLE:  if (tc && enable && activity) kick_next = K_REQ;
         K_REQ:   if (!aw_pending && !w_pending) kick_next = K_RESP;
         K_RESP:  if (m_axi_bvalid) kick_next = K_IDLE;
         default: kick_next = K_IDLE;
      endcase
   end

   // Kick decisions; a TC during an outstanding kick is an overlap error
   // and neither queues a kick nor consumes the activity flag.
   always_comb begin
      kick_issue   = (kick_state == K_IDLE) && tc && enable && activity;
      starve_set   = (kick_state == K_IDLE) && tc && enable && !activity;
      kick_err_set = (tc && (kick_state != K_IDLE)) ||
                     ((kick_state == K_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00));
   end

   // AXI outputs, activity and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_awaddr  <= 32'h0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= 32'h0;
         m_axi_wstrb   <= 4'h0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         activity      <= 1'b0;
         kick_err      <= 1'b0;
         starved       <= 1'b0;
      end else begin
         m_axi_wstrb   <= 4'hF;
         m_axi_awvalid <= kick_issue || aw_pending;
         m_axi_wvalid  <= kick_issue || w_pending;
         m_axi_bready  <= (kick_next == K_RESP);
         if (kick_issue) begin
            m_axi_awaddr <= KICK_ADDR;
            m_axi_wdata  <= KICK_DATA;
         end
         // An accept on the same cycle as a kick issue keeps the flag set
         activity <= accept || (activity && !kick_issue);
         kick_err <= kick_err_set || (kick_err && !err_clr);
         starved  <= starve_set || (starved && !err_clr);
      end
   end

endmodule

// File: tb/tb_boreal_cmd_sequencer.sv
// Testbench for boreal_cmd_sequencer: table-driven round-robin vectors,
// directed AXI corner sequences and a randomized run, all compared against
// a cycle-count based reference model.
module tb_boreal_cmd_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 2;
   localparam int KP   = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic            err_clr;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [8*N-1:0]  req_act;
   logic [16*N-1:0] req_val;
   logic [7:0]      fw_act;
   logic [15:0]     fw_val;
   logic            cmd_strobe;
   logic [2:0]      grant_id;
   logic [31:0]     m_axi_awaddr;
   logic            m_axi_awvalid;
   logic            m_axi_awready;
   logic [31:0]     m_axi_wdata;
   logic [3:0]      m_axi_wstrb;
   logic            m_axi_wvalid;
   logic            m_axi_wready;
   logic [1:0]      m_axi_bresp;
   logic            m_axi_bvalid;
   logic            m_axi_bready;
   logic            kick_err;
   logic            starved;

   always #5 clk = ~clk;

   boreal_cmd_sequencer #(
      .N_REQ       (N),
      .HOLD_CYCLES (HOLD),
      .KICK_PERIOD (KP),
      .WDT_BASE    (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .err_clr       (err_clr),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_act       (req_act),
      .req_val       (req_val),
      .fw_act        (fw_act),
      .fw_val        (fw_val),
      .cmd_strobe    (cmd_strobe),
      .grant_id      (grant_id),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .kick_err      (kick_err),
      .starved       (starved)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state (cycle index since reset release)
   int          m_cyc;
   int          m_idle_at;   // first cycle the arbiter may grant again
   int          m_ptr;
   bit          m_act;
   int          m_phase;     // 0 no kick, 1 AW/W outstanding, 2 waiting for B
   bit          m_awp;
   bit          m_wp;
   bit          m_kerr;
   bit          m_starv;
   logic [7:0]  m_fw_act;
   logic [15:0] m_fw_val;
   bit          m_strobe;
   int          m_gid;
   bit          m_in_reset;

   // Bench bookkeeping
   logic [N-1:0] pre_ready;
   int aw_hs, w_hs, b_hs, aw_hi, w_hi;
   int sl_aw_delay, sl_w_delay, sl_b_delay;
   logic [1:0] sl_bresp;
   int sl_age, sl_last_phase;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, m_cyc);
      end
   endtask

   task automatic m_reset();
      m_cyc = 0; m_idle_at = 0; m_ptr = 0; m_act = 0;
      m_phase = 0; m_awp = 0; m_wp = 0; m_kerr = 0; m_starv = 0;
      m_fw_act = 8'h00; m_fw_val = 16'h0000; m_strobe = 0; m_gid = 0;
   endtask

   // Winner under the round-robin rule, or -1 when nothing is granted
   function automatic int m_winner();
      if (m_cyc < m_idle_at) return -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic m_edge(input int w);
      bit tc, kick_issue, kset, sset;
      tc = (m_cyc % KP) == (KP - 1);
      kick_issue = 0; kset = 0; sset = 0;
      case (m_phase)
         0: if (tc && enable) begin
               if (m_act) begin
                  kick_issue = 1; m_phase = 1; m_awp = 1; m_wp = 1;
               end else begin
                  sset = 1;
               end
            end
         1: begin
               if (tc) kset = 1;
               if (m_awp && m_axi_awready) m_awp = 0;
               if (m_wp && m_axi_wready) m_wp = 0;
               if (!m_awp && !m_wp) m_phase = 2;
            end
         default: begin
               if (tc) kset = 1;
               if (m_axi_bvalid) begin
                  if (m_axi_bresp != 2'b00) kset = 1;
                  m_phase = 0;
               end
            end
      endcase
      m_strobe = (w >= 0);
      if (w >= 0) begin
         m_fw_act  = req_act[8*w +: 8];
         m_fw_val  = req_val[16*w +: 16];
         m_gid     = w;
         m_ptr     = (w + 1) % N;
         m_idle_at = m_cyc + HOLD + 1;
         m_act     = 1;
      end else if (kick_issue) begin
         m_act = 0;
      end
      m_kerr  = kset ? 1'b1 : (err_clr ? 1'b0 : m_kerr);
      m_starv = sset ? 1'b1 : (err_clr ? 1'b0 : m_starv);
      m_cyc++;
   endtask

   task automatic check_outputs();
      check("fw_act", fw_act, m_fw_act);
      check("fw_val", fw_val, m_fw_val);
      check("cmd_strobe", cmd_strobe, m_strobe);
      check("grant_id", grant_id, 3'(m_gid));
      check("awvalid", m_axi_awvalid, m_awp);
      check("wvalid", m_axi_wvalid, m_wp);
      check("bready", m_axi_bready, m_phase == 2);
      check("kick_err", kick_err, m_kerr);
      check("starved", starved, m_starv);
      if (m_awp) check("awaddr", m_axi_awaddr, 32'h0000_0004);
      if (m_wp) begin
         check("wdata", m_axi_wdata, 32'h1CEB_00DA);
         check("wstrb", m_axi_wstrb, 4'hF);
      end
      if (m_in_reset) begin
         check("rst_awaddr", m_axi_awaddr, 32'h0);
         check("rst_wdata", m_axi_wdata, 32'h0);
         check("rst_wstrb", m_axi_wstrb, 4'h0);
      end
   endtask

   // One clock: inputs are already driven by the caller
   task automatic run_cycle();
      int w;
      logic [N-1:0] exp_ready;
      #1;
      w = m_winner();
      exp_ready = '0;
      for (int i = 0; i < N; i++) exp_ready[i] = (w == i);
      pre_ready = req_ready;
      check("req_ready", req_ready, exp_ready);
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;
      if (m_axi_awvalid && m_axi_awready) aw_hs++;
      if (m_axi_wvalid && m_axi_wready) w_hs++;
      if (m_axi_bvalid && m_axi_bready) b_hs++;
      @(posedge clk);
      m_in_reset = rst;
      if (rst) m_reset();
      else m_edge(w);
      #1;
      check_outputs();
   endtask

   // Slave responder driven from the model's view of the transaction
   task automatic slave_cycle();
      if (m_phase != sl_last_phase) sl_age = 0;
      sl_last_phase = m_phase;
      m_axi_awready = (m_phase == 1) && (sl_age >= sl_aw_delay);
      m_axi_wready  = (m_phase == 1) && (sl_age >= sl_w_delay);
      m_axi_bvalid  = (m_phase == 2) && (sl_age >= sl_b_delay);
      m_axi_bresp   = m_axi_bvalid ? sl_bresp : 2'b00;
      run_cycle();
      sl_age++;
   endtask

   task automatic idle_inputs();
      enable = 0; err_clr = 0; req_valid = '0; req_act = '0; req_val = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
      sl_aw_delay = 0; sl_w_delay = 0; sl_b_delay = 0; sl_bresp = 2'b00;
      sl_age = 0; sl_last_phase = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      run_cycle();
      run_cycle();
      rst = 0;
      m_in_reset = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; aw_hi = 0; w_hi = 0;
   endtask

   // Single-cycle command from requester r, then the request drops
   task automatic send_one(input int r, input logic [7:0] a, input logic [15:0] v);
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_act[8*r +: 8] = a;
      req_val[16*r +: 16] = v;
      slave_cycle();
      req_valid = '0;
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] ready;
      logic         strobe;
      logic [7:0]   act;
      logic [2:0]   gid;
   } vec_t;

   vec_t tbl[19];

   initial begin
      tbl[0]  = '{4'b1111, 4'b0001, 1'b1, 8'd1, 3'd0};
      tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 8'd1, 3'd0};
      tbl[2]  = '{4'b1111, 4'b0000, 1'b0, 8'd1, 3'd0};
      tbl[3]  = '{4'b1111, 4'b0010, 1'b1, 8'd2, 3'd1};
      tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 8'd2, 3'd1};
      tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 8'd2, 3'd1};
      tbl[6]  = '{4'b1111, 4'b0100, 1'b1, 8'd3, 3'd2};
      tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 8'd3, 3'd2};
      tbl[8]  = '{4'b1111, 4'b0000, 1'b0, 8'd3, 3'd2};
      tbl[9]  = '{4'b1111, 4'b1000, 1'b1, 8'd4, 3'd3};
      tbl[10] = '{4'b1111, 4'b0000, 1'b0, 8'd4, 3'd3};
      tbl[11] = '{4'b1111, 4'b0000, 1'b0, 8'd4, 3'd3};
      tbl[12] = '{4'b1111, 4'b0001, 1'b1, 8'd1, 3'd0};
      tbl[13] = '{4'b1010, 4'b0000, 1'b0, 8'd1, 3'd0};
      tbl[14] = '{4'b1010, 4'b0000, 1'b0, 8'd1, 3'd0};
      tbl[15] = '{4'b1010, 4'b0010, 1'b1, 8'd2, 3'd1};
      tbl[16] = '{4'b0001, 4'b0000, 1'b0, 8'd2, 3'd1};
      tbl[17] = '{4'b0001, 4'b0000, 1'b0, 8'd2, 3'd1};
      tbl[18] = '{4'b0001, 4'b0001, 1'b1, 8'd1, 3'd0};

      m_reset();
      m_in_reset = 0;
      idle_inputs();
      rst = 1;
      @(posedge clk);
      #1;

      // Idle after reset: starved rises at the first terminal count
      do_reset();
      enable = 1;
      for (int c = 0; c < 20; c++) begin
         slave_cycle();
         if (c == KP - 2) check("idle_starved_early", starved, 1'b0);
         if (c == KP - 1) check("idle_starved_tc", starved, 1'b1);
      end
      check("idle_no_aw", 32'(aw_hs), 32'd0);

      // Round-robin table, kicks disabled
      do_reset();
      req_act = {8'd4, 8'd3, 8'd2, 8'd1};
      req_val = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
      for (int i = 0; i < 19; i++) begin
         req_valid = tbl[i].valid;
         run_cycle();
         check("tbl_ready", pre_ready, tbl[i].ready);
         check("tbl_strobe", cmd_strobe, tbl[i].strobe);
         check("tbl_fw_act", fw_act, tbl[i].act);
         check("tbl_grant", grant_id, tbl[i].gid);
      end

      // One command from requester 2, responsive slave: exactly one kick
      do_reset();
      enable = 1;
      send_one(2, 8'h55, 16'hBEEF);
      for (int c = 0; c < 19; c++) slave_cycle();
      check("one_fw_act", fw_act, 8'h55);
      check("one_fw_val", fw_val, 16'hBEEF);
      check("one_grant", grant_id, 3'd2);
      check("one_aw_hs", 32'(aw_hs), 32'd1);
      check("one_w_hs", 32'(w_hs), 32'd1);
      check("one_b_hs", 32'(b_hs), 32'd1);
      check("one_kick_err", kick_err, 1'b0);

      // awready delayed three cycles, wready immediate
      do_reset();
      enable = 1;
      sl_aw_delay = 3;
      send_one(0, 8'h11, 16'h2222);
      for (int c = 0; c < 19; c++) slave_cycle();
      check("dly_aw_hi", 32'(aw_hi), 32'd4);
      check("dly_w_hi", 32'(w_hi), 32'd1);
      check("dly_aw_hs", 32'(aw_hs), 32'd1);
      check("dly_b_hs", 32'(b_hs), 32'd1);

      // SLVERR response sets kick_err until err_clr
      do_reset();
      enable = 1;
      sl_bresp = 2'b10;
      send_one(1, 8'h21, 16'h0001);
      for (int c = 0; c < 11; c++) slave_cycle();
      check("slverr_set", kick_err, 1'b1);
      slave_cycle();
      check("slverr_hold", kick_err, 1'b1);
      err_clr = 1;
      slave_cycle();
      err_clr = 0;
      check("slverr_clr", kick_err, 1'b0);
      check("starved_clr", starved, 1'b0);

      // B withheld past a TC: overlap error, no extra AW, activity kept
      do_reset();
      enable = 1;
      sl_b_delay = 100;
      send_one(3, 8'h31, 16'h0031);
      for (int c = 1; c < 7; c++) slave_cycle();
      send_one(0, 8'h41, 16'h0041);
      for (int c = 8; c < 12; c++) slave_cycle();
      check("bwait_kick_err", kick_err, 1'b1);
      check("bwait_one_aw", 32'(aw_hs), 32'd1);
      sl_b_delay = 0;
      for (int c = 12; c < 20; c++) slave_cycle();
      check("bwait_second_aw", 32'(aw_hs), 32'd2);
      check("bwait_not_starved", starved, 1'b0);

      // Randomized traffic including mid-transaction resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         enable    = ($urandom_range(0, 7) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         req_valid = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         req_act   = {$urandom};
         req_val   = {$urandom, $urandom};
         m_axi_awready = $urandom_range(0, 1) == 1;
         m_axi_wready  = $urandom_range(0, 1) == 1;
         m_axi_bvalid  = (m_phase == 2) && ($urandom_range(0, 1) == 1);
         m_axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         run_cycle();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/boreal_cmd_sequencer.md
Name: boreal_cmd_sequencer

Overview:
- Sits between the firmware control tasks and the watchdog/safety-mux block.
- Round-robin arbitrates N requesters onto the single fw_act/fw_val command channel, holding each granted command for a minimum number of cycles.
- Acts as the AXI4-Lite write master that kicks the watchdog (write 0x1CEB00DA to offset 0x04), but only while commands are actually flowing. A stalled control loop therefore lets the watchdog force BRAKE.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 2, minimum cycles a granted command stays on fw_act/fw_val before the next grant (>=1)
- KICK_PERIOD, 6, cycles between kick attempts; must be below the watchdog timeout (10)
- WDT_BASE, 32'h0000_0000, watchdog base address; kicks go to WDT_BASE+0x04

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = kicks allowed; arbitration runs regardless
- err_clr  in  1  one-cycle pulse clears the sticky flags
- req_valid  in  N_REQ  per-requester command valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_act  in  8*N_REQ  packed action IDs; requester i uses bits [8i+7:8i]
- req_val  in  16*N_REQ  packed values; requester i uses bits [16i+15:16i]
- fw_act  out  8  registered command action to the watchdog
- fw_val  out  16  registered command value to the watchdog
- cmd_strobe  out  1  one-cycle pulse when fw_act/fw_val update
- grant_id  out  3  index of the last granted requester
- m_axi_awaddr  out  32  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobes, constant 4'hF
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- kick_err  out  1  sticky: SLVERR/DECERR response, or kick due while a kick is in flight
- starved  out  1  sticky: kick skipped because no command was accepted in the period

Behaviour:
- Reset: all outputs 0. Internal state after reset: arbiter in A_IDLE, kick FSM in K_IDLE, period counter 0, activity flag 0, round-robin pointer at requester 0.
- Arbiter FSM
  - A_IDLE: req_ready[w] = 1 combinationally, where w is the first requester with valid set searching from ptr upward, wrapping.
  - On that cycle: capture fw_act/fw_val from requester w, pulse cmd_strobe the next cycle, set grant_id = w, set ptr = w+1 mod N_REQ, set the activity flag, go to A_HOLD.
  - A_HOLD: req_ready = 0. Count HOLD_CYCLES cycles, then return to A_IDLE.
  - Maximum acceptance rate is 1 command per HOLD_CYCLES+1 cycles.
  - fw_act/fw_val retain their last value indefinitely.
- Period counter: free-runs 0..KICK_PERIOD-1 and wraps. The terminal count (TC) is the cycle where it equals KICK_PERIOD-1.
- Kick FSM
  - K_IDLE, at TC:
    - enable=1 and activity=1: go to K_REQ and clear activity.
    - enable=1 and activity=0: set starved; no kick.
    - enable=0: nothing.
  - K_REQ: awvalid and wvalid are both asserted, with awaddr = WDT_BASE+0x04 and wdata = 32'h1CEB00DA.
    - Each valid drops independently on the cycle after its own ready is sampled high.
    - When both have been accepted, go to K_RESP. Simultaneous acceptance is legal; the watchdog accepts AW and W together.
  - K_RESP: bready = 1. On bvalid: bresp != 2'b00 sets kick_err. Go to K_IDLE.
  - TC while in K_REQ or K_RESP: set kick_err. Do not queue a kick and do not clear activity.
- Activity flag: set on a command accept, cleared on kick issue. A simultaneous accept and clear leaves it set.
- Sticky flags: err_clr clears kick_err and starved. A set on the same cycle as err_clr wins.
- enable dropping mid-transaction: the outstanding transaction completes normally.
- rst mid-transaction: state aborts immediately and awvalid/wvalid drop. The slave is also reset with the system.
- grant_id uses 3 bits; the upper bits are 0 when N_REQ < 8.

Test Plan:
- rst=1 for 2 cycles, then idle for 20 cycles → all outputs 0; starved rises at cycle KICK_PERIOD-1 after reset release; no AXI activity.
- req_valid=4'b1111, act[i]=i+1, val[i]=0x100*i, held continuously → grants in order 0,1,2,3,0 every 3 cycles; fw_act sequence 1,2,3,4,1; one-hot req_ready; cmd_strobe pulses each update.
- Requester 2 sends one command, enable=1, slave ready every cycle → at the next TC: exactly one write, awaddr=0x04, wdata=0x1CEB00DA, wstrb=0xF; bresp=0 → kick_err stays 0; no second kick without a new command.
- awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid holds until accepted, then exactly one B handshake.
- bresp=2'b10 → kick_err=1 and stays high; err_clr pulse → 0.
- bvalid withheld for more than KICK_PERIOD cycles → kick_err set at TC; no second AW issued; activity stays set.
